// File: rtl/param_cpu_core.sv
// rtl/param_cpu_core.sv - parametrised multi-cycle accumulator/register CPU core
module param_cpu_core #(
  parameter int  DATA_W   = 8,
  parameter int  NUM_REGS = 4,
  parameter int  ADDR_W   = 8,
  localparam int RS_W     = $clog2(NUM_REGS),
  localparam int INSTR_W  = 4 + 2 * RS_W
) (
  input  logic               one_shot_clock,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [INSTR_W-1:0] ir,
  output logic               carry,
  output logic               zero,
  output logic               halted,
  output logic               phase,
  input  logic [RS_W-1:0]    dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_LDA  = 4'h9;
  localparam logic [3:0] OP_LDB  = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_JNZ  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic                adv;
  logic [3:0]          opcode;
  logic [RS_W-1:0]     rd;
  logic [RS_W-1:0]     rs;
  logic [DATA_W-1:0]   r_val;
  logic [DATA_W-1:0]   s_val;
  logic [2*DATA_W-1:0] product;
  logic [ADDR_W-1:0]   jump_target;

  logic [DATA_W-1:0]   result;
  logic                carry_new;
  logic                wr_en;
  logic                upd_zero;
  logic                upd_carry;
  logic                do_out;
  logic                do_jump;
  logic                is_halt;

  assign adv         = run | step;
  assign opcode      = ir[INSTR_W-1 -: 4];
  assign rd          = ir[2*RS_W-1 -: RS_W];
  assign rs          = ir[RS_W-1:0];
  assign r_val       = regs[rd];
  assign s_val       = regs[rs];
  assign product     = {{DATA_W{1'b0}}, r_val} * {{DATA_W{1'b0}}, s_val};
  // Size cast truncates a wide operand or zero-extends a narrow one.
  assign jump_target = ADDR_W'(s_val);

  assign instr_addr  = pc;
  assign phase       = (state != ST_FETCH);
  assign halted      = (state == ST_HALT);
  assign dbg_data    = regs[dbg_sel];

  // Decode the held instruction and compute its result, flags and side effects.
  always_comb begin
    result    = r_val;
    carry_new = carry;
    wr_en     = (opcode <= OP_LDB);
    upd_zero  = (opcode <= OP_LDB);
    upd_carry = (opcode <= OP_OR);
    do_out    = 1'b0;
    do_jump   = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      OP_ADD:  {carry_new, result} = {1'b0, r_val} + {1'b0, s_val};
      OP_SUB:  {carry_new, result} = {1'b0, r_val} - {1'b0, s_val};
      OP_MUL: begin
        result    = product[DATA_W-1:0];
        carry_new = |product[2*DATA_W-1:DATA_W];
      end
      OP_DIV: begin
        if (s_val == '0) begin
          result    = '1;
          carry_new = 1'b1;
        end else begin
          result    = r_val / s_val;
          carry_new = 1'b0;
        end
      end
      OP_SHL: begin
        result    = {r_val[DATA_W-2:0], 1'b0};
        carry_new = r_val[DATA_W-1];
      end
      OP_SHR: begin
        result    = {1'b0, r_val[DATA_W-1:1]};
        carry_new = r_val[0];
      end
      OP_AND: begin
        result    = r_val & s_val;
        carry_new = 1'b0;
      end
      OP_OR: begin
        result    = r_val | s_val;
        carry_new = 1'b0;
      end
      OP_MOV:  result  = s_val;
      OP_LDA:  result  = in_a;
      OP_LDB:  result  = in_b;
      OP_OUT:  do_out  = 1'b1;
      OP_JNZ:  do_jump = (r_val != '0);
      OP_JMP:  do_jump = 1'b1;
      OP_NOP:  do_jump = 1'b0;
      OP_HALT: is_halt = 1'b1;
      default: result  = r_val;
    endcase
  end

  // Phase state register; reset overrides HALT and any partial instruction.
  always_ff @(posedge one_shot_clock) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next phase: alternate FETCH/EXECUTE on advancing edges, park in HALT.
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: if (adv) state_next = ST_EXEC;
      ST_EXEC:  if (adv) state_next = is_halt ? ST_HALT : ST_FETCH;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_FETCH;
    endcase
  end

  // Architectural state: fetch latches ir and bumps pc, execute commits results.
  always_ff @(posedge one_shot_clock) begin
    if (reset) begin
      pc        <= '0;
      ir        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (adv && state == ST_FETCH) begin
        ir <= instr_data;
        pc <= pc + ADDR_W'(1);
      end else if (adv && state == ST_EXEC) begin
        if (wr_en) begin
          regs[rd] <= result;
        end
        if (upd_zero) begin
          zero <= (result == '0);
        end
        if (upd_carry) begin
          carry <= carry_new;
        end
        if (do_out) begin
          out_data  <= r_val;
          out_valid <= 1'b1;
        end
        if (do_jump) begin
          pc <= jump_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_cpu_core.sv
// tb/tb_param_cpu_core.sv - self-checking bench for param_cpu_core at two parameter sets
module tb_param_cpu_core;

  logic clk = 1'b0;
  logic reset, run, step;

  // instance 1: defaults (8-bit data, 4 regs, 8-bit pc, 8-bit instr)
  logic [7:0]  addr1, idata1, in_a1, in_b1, out1, ir1, dbg1;
  logic        ov1, c1, z1, h1, ph1;
  logic [1:0]  dsel1;
  // instance 2: 12-bit data, 8 regs, 4-bit pc, 10-bit instr
  logic [3:0]  addr2;
  logic [9:0]  idata2, ir2;
  logic [11:0] in_a2, in_b2, out2, dbg2;
  logic        ov2, c2, z2, h2, ph2;
  logic [2:0]  dsel2;

  logic [7:0] rom1 [256];
  logic [9:0] rom2 [16];
  assign idata1 = rom1[addr1];
  assign idata2 = rom2[addr2];

  always #5 clk = ~clk;

  param_cpu_core u_dut1 (
    .one_shot_clock(clk), .reset(reset), .run(run), .step(step),
    .instr_addr(addr1), .instr_data(idata1), .in_a(in_a1), .in_b(in_b1),
    .out_data(out1), .out_valid(ov1), .ir(ir1), .carry(c1), .zero(z1),
    .halted(h1), .phase(ph1), .dbg_sel(dsel1), .dbg_data(dbg1)
  );

  param_cpu_core #(.DATA_W(12), .NUM_REGS(8), .ADDR_W(4)) u_dut2 (
    .one_shot_clock(clk), .reset(reset), .run(run), .step(step),
    .instr_addr(addr2), .instr_data(idata2), .in_a(in_a2), .in_b(in_b2),
    .out_data(out2), .out_valid(ov2), .ir(ir2), .carry(c2), .zero(z2),
    .halted(h2), .phase(ph2), .dbg_sel(dsel2), .dbg_data(dbg2)
  );

  logic [33:0] snap_ctl;
  logic [59:0] snap_all;
  assign snap_ctl = {addr1, ir1, ph1, h1, addr2, ir2, ph2, h2};
  assign snap_all = {snap_ctl, out1, ov1, c1, z1, out2, ov2, c2, z2};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // program shared by both instances (registers 0..3 only)
  int p_op [16];
  int p_rd [16];
  int p_rs [16];

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      p_op[i] = 14; p_rd[i] = 0; p_rs[i] = 0;
    end
  endtask

  task automatic put(input int a, input int op, input int rd, input int rs);
    p_op[a] = op; p_rd[a] = rd; p_rs[a] = rs;
  endtask

  task automatic load_roms();
    for (int i = 0; i < 256; i++) rom1[i] = 8'hE0;
    for (int i = 0; i < 16; i++) begin
      rom1[i] = {p_op[i][3:0], p_rd[i][1:0], p_rs[i][1:0]};
      rom2[i] = {p_op[i][3:0], p_rd[i][2:0], p_rs[i][2:0]};
    end
  endtask

  // instruction-level reference model
  longint m_reg [8];
  longint m_out;
  int     m_pc, m_nout, m_nexec, m_nsub;
  bit     m_c, m_z, m_halt;

  task automatic model_run(input int w, input int aw, input longint a, input longint b);
    longint mask, r, s, res;
    int op, rd, rs, depth;
    mask = (64'd1 << w) - 1;
    depth = 1 << aw;
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_out = 0; m_pc = 0; m_nout = 0; m_nexec = 0; m_nsub = 0;
    m_c = 0; m_z = 0; m_halt = 0;
    for (int n = 0; n < 2000 && !m_halt; n++) begin
      op = (m_pc < 16) ? p_op[m_pc] : 14;
      rd = (m_pc < 16) ? p_rd[m_pc] : 0;
      rs = (m_pc < 16) ? p_rs[m_pc] : 0;
      m_pc = (m_pc + 1) % depth;
      r = m_reg[rd]; s = m_reg[rs]; res = 0;
      m_nexec++;
      if (op == 1) m_nsub++;
      case (op)
        0:  begin res = r + s; m_c = (res > mask); end
        1:  begin res = r - s; m_c = (r < s); end
        2:  begin res = r * s; m_c = ((res >> w) != 0); end
        3:  if (s == 0) begin res = mask; m_c = 1; end
            else begin res = r / s; m_c = 0; end
        4:  begin res = r * 2; m_c = r[w-1]; end
        5:  begin res = r / 2; m_c = r[0]; end
        6:  begin res = r & s; m_c = 0; end
        7:  begin res = r | s; m_c = 0; end
        8:  res = s;
        9:  res = a;
        10: res = b;
        11: begin m_out = r; m_nout++; end
        12: if (r != 0) m_pc = int'(s % depth);
        13: m_pc = int'(s % depth);
        15: m_halt = 1;
        default: res = 0;
      endcase
      if (op <= 10) begin
        res = res & mask;
        m_reg[rd] = res;
        m_z = (res == 0);
      end
    end
  endtask

  // run observation
  int o_cyc, o_nout1, o_nout2, o_exec1, o_exec2, o_sub1, o_sub2, o_ovcyc1, o_hcyc1;
  bit o_wrap1, o_wrap2;

  task automatic run_prog(input int budget);
    logic [7:0] prev1;
    logic [3:0] prev2;
    o_cyc = 0; o_nout1 = 0; o_nout2 = 0; o_exec1 = 0; o_exec2 = 0;
    o_sub1 = 0; o_sub2 = 0; o_ovcyc1 = 0; o_hcyc1 = 0; o_wrap1 = 0; o_wrap2 = 0;
    prev1 = addr1; prev2 = addr2;
    run = 1'b1;
    for (int n = 0; n < budget; n++) begin
      tick();
      o_cyc++;
      if (ov1) begin o_nout1++; if (o_ovcyc1 == 0) o_ovcyc1 = o_cyc; end
      if (ov2) o_nout2++;
      if (ph1 && !h1) begin o_exec1++; if (ir1[7:4] == 4'h1) o_sub1++; end
      if (ph2 && !h2) begin o_exec2++; if (ir2[9:6] == 4'h1) o_sub2++; end
      if (prev1 == 8'hFF && addr1 == 8'h00) o_wrap1 = 1;
      if (prev2 == 4'hF && addr2 == 4'h0) o_wrap2 = 1;
      prev1 = addr1; prev2 = addr2;
      if (h1 && o_hcyc1 == 0) o_hcyc1 = o_cyc;
      if (h1 && h2) break;
    end
    run = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    model_run(8, 8, longint'(in_a1), longint'(in_b1));
    for (int i = 0; i < 4; i++) begin
      dsel1 = 2'(i); #1;
      chk($sformatf("%s_d1_r%0d", tag, i), dbg1, m_reg[i]);
    end
    chk({tag, "_d1_carry"}, c1, m_c);
    chk({tag, "_d1_zero"}, z1, m_z);
    chk({tag, "_d1_out"}, out1, m_out);
    chk({tag, "_d1_nout"}, o_nout1, m_nout);
    chk({tag, "_d1_nexec"}, o_exec1, m_nexec);
    chk({tag, "_d1_halted"}, h1, m_halt);
    chk({tag, "_d1_pc"}, addr1, m_pc);
    model_run(12, 4, longint'(in_a2), longint'(in_b2));
    for (int i = 0; i < 8; i++) begin
      dsel2 = 3'(i); #1;
      chk($sformatf("%s_d2_r%0d", tag, i), dbg2, m_reg[i]);
    end
    chk({tag, "_d2_carry"}, c2, m_c);
    chk({tag, "_d2_zero"}, z2, m_z);
    chk({tag, "_d2_out"}, out2, m_out);
    chk({tag, "_d2_nout"}, o_nout2, m_nout);
    chk({tag, "_d2_nexec"}, o_exec2, m_nexec);
    chk({tag, "_d2_halted"}, h2, m_halt);
    chk({tag, "_d2_pc"}, addr2, m_pc);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc1"}, addr1, 0);  chk({tag, "_pc2"}, addr2, 0);
    chk({tag, "_ir1"}, ir1, 0);    chk({tag, "_ir2"}, ir2, 0);
    chk({tag, "_out1"}, out1, 0);  chk({tag, "_out2"}, out2, 0);
    chk({tag, "_ov"}, {ov1, ov2}, 0);
    chk({tag, "_flags1"}, {c1, z1}, 0);
    chk({tag, "_flags2"}, {c2, z2}, 0);
    chk({tag, "_halted"}, {h1, h2}, 0);
    chk({tag, "_phase"}, {ph1, ph2}, 0);
    for (int i = 0; i < 8; i++) begin
      dsel1 = 2'(i); dsel2 = 3'(i); #1;
      if (i < 4) chk($sformatf("%s_d1_r%0d", tag, i), dbg1, 0);
      chk($sformatf("%s_d2_r%0d", tag, i), dbg2, 0);
    end
  endtask

  task automatic load_default_prog();
    clear_prog();
    put(0, 9, 0, 0);    // LDA r0
    put(1, 10, 1, 0);   // LDB r1
    put(2, 0, 0, 1);    // ADD r0,r1
    put(3, 11, 0, 0);   // OUT r0
    put(4, 15, 0, 0);   // HALT
    load_roms();
  endtask

  typedef struct {
    int op; int rs; int a; int b; int r; int c; int z;
  } vec_t;
  vec_t vt [13];

  logic [33:0] prev_ctl;
  logic [59:0] prev_all;
  int          rnd_ops [13];

  initial begin
    vt[0]  = '{0, 1, 'hFF, 'h01, 'h00, 1, 1};  // ADD overflow
    vt[1]  = '{1, 1, 'h03, 'h05, 'hFE, 1, 0};  // SUB borrow
    vt[2]  = '{2, 1, 'h10, 'h10, 'h00, 1, 1};  // MUL high half
    vt[3]  = '{3, 1, 'h09, 'h00, 'hFF, 1, 0};  // DIV by zero
    vt[4]  = '{3, 1, 'h09, 'h02, 'h04, 0, 0};  // DIV
    vt[5]  = '{5, 1, 'h03, 'h00, 'h01, 1, 0};  // SHR
    vt[6]  = '{4, 1, 'h81, 'h00, 'h02, 1, 0};  // SHL
    vt[7]  = '{6, 1, 'hF0, 'h0F, 'h00, 0, 1};  // AND
    vt[8]  = '{7, 1, 'hA0, 'h05, 'hA5, 0, 0};  // OR
    vt[9]  = '{8, 1, 'h05, 'h00, 'h00, 0, 1};  // MOV, carry untouched
    vt[10] = '{0, 0, 'h41, 'h07, 'h82, 0, 0};  // ADD r0,r0
    vt[11] = '{1, 1, 'h05, 'h05, 'h00, 0, 1};  // SUB to zero
    vt[12] = '{2, 1, 'h0F, 'h11, 'hFF, 0, 0};  // MUL no overflow
    rnd_ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 14};

    reset = 1'b1; run = 1'b0; step = 1'b0;
    dsel1 = '0; dsel2 = '0;
    in_a1 = '0; in_b1 = '0; in_a2 = '0; in_b2 = '0;

    // defaults program with cycle-exact timing
    load_default_prog();
    in_a1 = 8'h7F; in_b1 = 8'h01; in_a2 = 12'h7FF; in_b2 = 12'h001;
    do_reset();
    check_reset_state("reset");
    run_prog(12);
    chk("def_out", out1, 'h80);
    chk("def_ov_count", o_nout1, 1);
    chk("def_ov_cycle", o_ovcyc1, 8);
    chk("def_halt_cycle", o_hcyc1, 10);
    chk("def_flags", {c1, z1}, 0);
    chk("def_out2", out2, 'h800);
    compare_model("def");

    // ALU vector table
    for (int i = 0; i < 13; i++) begin
      clear_prog();
      put(0, 9, 0, 0);
      put(1, 10, 1, 0);
      put(2, vt[i].op, 0, vt[i].rs);
      put(3, 11, 0, 0);
      put(4, 15, 0, 0);
      load_roms();
      in_a1 = 8'(vt[i].a); in_b1 = 8'(vt[i].b);
      in_a2 = 12'(vt[i].a); in_b2 = 12'(vt[i].b);
      do_reset();
      run_prog(40);
      dsel1 = 2'd0; #1;
      chk($sformatf("vec%0d_r0", i), dbg1, vt[i].r);
      chk($sformatf("vec%0d_out", i), out1, vt[i].r);
      chk($sformatf("vec%0d_carry", i), c1, vt[i].c);
      chk($sformatf("vec%0d_zero", i), z1, vt[i].z);
      compare_model($sformatf("vec%0d", i));
    end

    // countdown loop: SUB r0,r1 ; JNZ r0,r2 three times
    clear_prog();
    put(0, 9, 0, 0);    // LDA r0 = 3
    put(1, 10, 2, 0);   // LDB r2 = 4 (loop address)
    put(2, 8, 1, 2);    // MOV r1,r2
    put(3, 3, 1, 2);    // DIV r1,r2 -> 1
    put(4, 1, 0, 1);    // SUB r0,r1
    put(5, 12, 0, 2);   // JNZ r0,r2
    put(6, 15, 0, 0);   // HALT
    load_roms();
    in_a1 = 8'd3; in_b1 = 8'd4; in_a2 = 12'd3; in_b2 = 12'd4;
    do_reset();
    run_prog(100);
    chk("loop_sub_count1", o_sub1, 3);
    chk("loop_sub_count2", o_sub2, 3);
    dsel1 = 2'd0; #1;
    chk("loop_r0", dbg1, 0);
    chk("loop_zero", z1, 1);
    chk("loop_halted", h1, 1);
    compare_model("loop");

    // pc wrap to 0, then a taken JNZ to HALT
    clear_prog();
    put(0, 12, 1, 2);   // JNZ r1,r2 (not taken on first pass)
    put(1, 10, 3, 0);   // LDB r3 = 10
    put(2, 8, 2, 3);    // MOV r2,r3
    put(3, 5, 2, 0);    // SHR r2 -> 5
    put(4, 13, 0, 3);   // JMP r3
    put(5, 15, 0, 0);   // HALT
    put(10, 9, 0, 0);   // LDA r0
    put(11, 0, 0, 3);   // ADD r0,r3
    put(12, 11, 0, 0);  // OUT r0
    put(13, 8, 1, 3);   // MOV r1,r3
    load_roms();
    in_a1 = 8'hFA; in_b1 = 8'd10; in_a2 = 12'hFFA; in_b2 = 12'd10;
    do_reset();
    run_prog(700);
    chk("wrap_seen1", o_wrap1, 1);
    chk("wrap_seen2", o_wrap2, 1);
    chk("wrap_out1", out1, 'h04);
    chk("wrap_out2", out2, 'h004);
    chk("wrap_carry", {c1, c2}, 3);
    compare_model("wrap");

    // random straight-line programs
    for (int t = 0; t < 20; t++) begin
      clear_prog();
      for (int i = 0; i < 12; i++) begin
        put(i, rnd_ops[$urandom_range(0, 12)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      put(12, 15, 0, 0);
      load_roms();
      in_a1 = 8'($urandom); in_b1 = 8'($urandom_range(0, 3));
      in_a2 = 12'($urandom); in_b2 = 12'($urandom_range(0, 3));
      do_reset();
      run_prog(60);
      compare_model($sformatf("rnd%0d", t));
    end

    // single-step: run=0, step every 4th clock
    load_default_prog();
    in_a1 = 8'h7F; in_b1 = 8'h01; in_a2 = 12'h7FF; in_b2 = 12'h001;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      prev_ctl = snap_ctl;
      step = (k % 4 == 3);
      tick();
      if (step) begin
        chk($sformatf("step_adv%0d", k), snap_ctl != prev_ctl, 1);
      end else begin
        chk($sformatf("step_hold%0d", k), snap_ctl, prev_ctl);
        chk($sformatf("step_ov%0d", k), {ov1, ov2}, 0);
      end
      step = 1'b0;
    end
    chk("step_out", out1, 'h80);
    chk("step_halted", {h1, h2}, 3);
    prev_all = snap_all;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("idle_hold%0d", k), snap_all, prev_all);
    end

    // reset in EXECUTE of ADD, then reset while halted
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_phase", ph1, 1);
    chk("mid_ir", ir1, 'h01);
    reset = 1'b1;
    tick();
    check_reset_state("rst_exec");
    run = 1'b0;
    reset = 1'b0;
    run_prog(40);
    chk("rerun_halted", {h1, h2}, 3);
    chk("rerun_out", out1, 'h80);
    run = 1'b1;
    reset = 1'b1;
    tick();
    check_reset_state("rst_halt");
    run = 1'b0;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
